// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants, state encoding and index-width helper for the radix-8 NTT scheduler.
package ntt_pkg;
  localparam int RADIX_LOG = 3;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;
  function automatic int IDX_W(input int stages);
    return RADIX_LOG * stages;
  endfunction
endpackage

// File: rtl/ntt_sched_delay.sv
// ntt_sched_delay: LAT-deep valid/payload shift register aligning side-band data with the datapath.
module ntt_sched_delay #(
  parameter int LAT = 4,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  logic [LAT-1:0]        v_q, v_d;
  logic [LAT-1:0][W-1:0] d_q, d_d;
  always_comb begin
    v_d[0] = in_valid;
    d_d[0] = in_data;
    for (int i = 1; i < LAT; i++) begin
      v_d[i] = v_q[i-1];
      d_d[i] = d_q[i-1];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end
  assign out_valid = v_q[LAT-1];
  assign out_data  = d_q[LAT-1];
endmodule

// File: rtl/ntt_radix8_sched.sv
// ntt_radix8_sched: stage/group sequencer for the radix-8 NTT butterfly datapath.
module ntt_radix8_sched
  import ntt_pkg::*;
#(
  parameter int WIDTH  = 18,
  parameter int STAGES = 3,
  parameter int LAT    = 4,
  localparam int IW    = IDX_W(STAGES),
  localparam int SW    = $clog2(STAGES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          rd_ready,
  output logic          busy,
  output logic          done,
  output logic          rd_valid,
  output logic [IW-1:0] rd_base,
  output logic [IW-1:0] rd_shift,
  output logic [SW-1:0] rd_stage,
  output logic [IW-1:0] tw_idx,
  output logic          wr_valid,
  output logic [IW-1:0] wr_base,
  output logic [IW-1:0] wr_shift
);
  localparam int GW = IW - RADIX_LOG;
  localparam int CW = $clog2(LAT + 1) + 1;

  if (WIDTH < 1 || STAGES < 2 || STAGES > 5 || LAT < 1) begin : g_bad_param
    $error("ntt_radix8_sched: illegal WIDTH/STAGES/LAT");
  end

  state_e        state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [GW-1:0] g_q, g_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [IW-1:0] rem, e, s3, off, blk, base, tw;
  logic          issue, acc, last_g, last_s;
  logic [2*IW-1:0] wr_data;

  // Stride exponent and twiddle shift are 3*x built as (x<<1)+x.
  always_comb begin
    rem  = IW'(STAGES - 1) - IW'(s_q);
    e    = (rem << 1) + rem;
    s3   = (IW'(s_q) << 1) + IW'(s_q);
    off  = IW'(g_q) & ~({IW{1'b1}} << e);
    blk  = IW'(g_q) >> e;
    base = (blk << (e + IW'(RADIX_LOG))) | off;
    tw   = off << s3;
  end

  assign issue      = state_q == ISSUE;
  assign acc        = issue & rd_ready;
  assign last_g     = &g_q;
  assign last_s     = s_q == SW'(STAGES - 1);
  assign inflight_d = inflight_q + CW'(acc) - CW'(wr_valid);

  // DRAIN looks at the post-update count so the next stage starts right after the last write-back.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    g_d     = g_q;
    case (state_q)
      IDLE:  if (start) begin
        state_d = ISSUE;
        s_d     = '0;
        g_d     = '0;
      end
      ISSUE: if (acc) begin
        g_d = g_q + 1'b1;
        if (last_g) state_d = DRAIN;
      end
      DRAIN: if (inflight_d == '0) begin
        if (last_s) state_d = DONE;
        else begin
          state_d = ISSUE;
          s_d     = s_q + 1'b1;
          g_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      s_q        <= '0;
      g_q        <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      g_q        <= g_d;
      inflight_q <= inflight_d;
    end
  end

  assign rd_valid = issue;
  assign rd_base  = issue ? base : '0;
  assign rd_shift = issue ? e : '0;
  assign rd_stage = issue ? s_q : '0;
  assign tw_idx   = issue ? tw : '0;
  assign busy     = issue | (state_q == DRAIN);
  assign done     = state_q == DONE;

  ntt_sched_delay #(.LAT(LAT), .W(2 * IW)) u_delay (
    .clk      (clk),
    .rst      (rst),
    .in_valid (acc),
    .in_data  (acc ? {base, e} : '0),
    .out_valid(wr_valid),
    .out_data (wr_data)
  );

  assign {wr_base, wr_shift} = wr_data;
endmodule
